movwide_imm_encoder: RTL

//   Inverse of the datapath immediate extender. Takes a 64-bit constant and a

---
 rtl/movwide_imm_encoder.sv | 113 +++++++++++
 1 files changed

// File: rtl/movwide_imm_encoder.sv
//------------------------------------------------------------------------------
// movwide_imm_encoder: turns a 64-bit constant into the shortest MOVZ/MOVK run.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module movwide_imm_encoder #(
  parameter logic [8:0] OPC_MOVZ  = 9'b110100101,
  parameter logic [8:0] OPC_MOVK  = 9'b111100101,
  parameter bit         SKIP_ZERO = 1'b1
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] imm,
  input  logic [4:0]  rd,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic        inst_last,
  output logic        busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t      state;
  logic [63:0] imm_q;
  logic [4:0]  rd_q;
  logic [3:0]  mask;

  logic [3:0]  new_mask;
  logic [3:0]  src_mask;
  logic [63:0] src_imm;
  logic [4:0]  src_rd;
  logic [1:0]  sel_hw;
  logic [3:0]  rest_mask;
  logic [15:0] sel_chunk;
  logic [31:0] next_word;

  // A request whose chunks are all zero still needs one MOVZ of chunk 0.
  always_comb begin
    new_mask = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      new_mask[k] = (imm[16*k +: 16] != 16'h0000) || !SKIP_ZERO;
    end
    if (new_mask == 4'b0000) begin
      new_mask = 4'b0001;
    end
  end

  // In IDLE the first word is built straight from the request inputs.
  always_comb begin
    src_mask = (state == IDLE) ? new_mask : mask;
    src_imm  = (state == IDLE) ? imm      : imm_q;
    src_rd   = (state == IDLE) ? rd       : rd_q;
    sel_hw   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (src_mask[k]) begin
        sel_hw = k[1:0];
      end
    end
    rest_mask = src_mask & ~(4'b0001 << sel_hw);
    sel_chunk = src_imm[{sel_hw, 4'b0000} +: 16];
    next_word = {(state == IDLE) ? OPC_MOVZ : OPC_MOVK, sel_hw, sel_chunk, src_rd};
  end

  assign in_ready = (state == IDLE) && !Reset;
  assign busy     = (state == EMIT);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      imm_q      <= 64'h0;
      rd_q       <= 5'h0;
      mask       <= 4'h0;
      inst_valid <= 1'b0;
      inst       <= 32'h0;
      inst_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state      <= EMIT;
            imm_q      <= imm;
            rd_q       <= rd;
            mask       <= rest_mask;
            inst_valid <= 1'b1;
            inst       <= next_word;
            inst_last  <= (rest_mask == 4'b0000);
          end
        end
        EMIT: begin
          if (inst_valid && inst_ready) begin
            if (inst_last) begin
              state      <= IDLE;
              inst_valid <= 1'b0;
              inst_last  <= 1'b0;
            end else begin
              mask      <= rest_mask;
              inst      <= next_word;
              inst_last <= (rest_mask == 4'b0000);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
